pow2_decomp_stream: RTL and testbench
=====================================

# pow2_decomp_stream

Parametrised streaming powers-of-two expander for key-switching and relinearisation key generation. It loads an N-coefficient polynomial s over a valid/ready stream. It then emits s·2^i mod Q for i = 0..K-1, power-major and coefficient-minor. It sits between the secret-key sampler and the relinearisation key assembler, and it replaces the fixed 1024×40 unreduced-shift design with configurable sizes, modular reduction, back-pressure and re-triggering.

## Interface
- N, 1024: coefficients per polynomial (≥ 2)
- K, 40: number of powers emitted (≥ 1)
- W, 10: coefficient width in bits
- Q, 1009: modulus; 2 ≤ Q < 2^W
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin; sampled only in IDLE
- in_data  input  W  coefficient s[j], j ascending
- in_valid  input  1  in_data valid
- in_ready  output  1  high in LOAD only
- out_data  output  W  s[j]·2^i mod Q
- out_pow  output  clog2(K)  power index i of out_data
- out_idx  output  clog2(N)  coefficient index j of out_data
- out_last  output  1  high with final beat (i = K-1, j = N-1)
- out_valid  output  1  output beat valid
- out_ready  input  1  consumer accepts beat
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the final output handshake

## Operation
- States: IDLE, LOAD, EMIT, DONE.
- IDLE: start=1 moves the block to LOAD. start in any other state is ignored.
- LOAD: in_ready=1. Each in_valid handshake writes the coefficient to buffer[j], then j increments. If in_data ≥ Q, the stored value is in_data − Q (single conditional subtract, truncated to W bits). After beat j = N-1 the block moves to EMIT with j=0, i=0.
- EMIT, pass i:
  - For each j, read buffer[j] and present it as out_data.
  - On handshake, write back buffer[j] ← dbl(buffer[j]).
  - After j = N-1, increment i. After i = K-1 and j = N-1, move to DONE.
- dbl(x) with the macro: compute t = 2x in W+1 bits; result is t−Q if t ≥ Q, else t. Result is always < Q.
- DONE: done=1 for exactly one cycle, then IDLE. The block can be re-started immediately.
- The buffer is single-port N×W. Its contents are destroyed by EMIT; a new start requires a fresh LOAD.
- Reset mid-operation: block goes to IDLE. Counters and all outputs clear. Buffer contents are undefined. Any partially emitted sequence is abandoned.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_pow=0, out_idx=0, out_last=0, busy=0, done=0.
- start→LOAD: in_ready rises one cycle after start is sampled in IDLE.
- LOAD→EMIT: first out_valid asserts on the second rising edge after the edge that accepts beat N-1.
- Throughput: 1 output per cycle while out_ready=1, including across pass boundaries (no bubble between j = N-1 and j = 0 of the next pass).
- Back-pressure: while out_valid=1 and out_ready=0, out_data, out_pow, out_idx and out_last hold stable. No write-back occurs and no counter advances.
- done asserts the cycle after the out_last handshake. busy falls with the return to IDLE, i.e. one cycle after done.
- Minimum total cycles with no stalls: N (load) + 2 + N·K (emit) + 1 (done).

## Configuration
- POW2_MODRED_EN defined: dbl performs modular doubling mod Q as above, and the LOAD input reduction is active.
- POW2_MODRED_EN undefined:
  - dbl(x) = (x << 1) truncated to W bits (plain shift, no modulus).
  - Input is stored unreduced.
  - Q is unused.
  - All handshakes and timing are identical.

## Test plan
- Modular expansion (N=4, K=3, W=5, Q=17, macro on): load 1,5,16,9 → outputs 1,5,16,9 | 2,10,15,1 | 4,3,13,2. out_last only on the 12th beat. done one cycle later.
- Input reduction (same config, macro on): load 17,0,3,20 → pass 0 is 0,0,3,3; pass 1 is 0,0,6,6.
- Macro off (same config): load 1,5,16,9 → 1,5,16,9 | 2,10,0,18 | 4,20,0,4.
- Back-pressure: random out_ready toggling at 50% → sequence identical to the stall-free run, and outputs are held stable during every stall.
- Reset mid-EMIT: assert reset at beat 6 → all outputs 0 and busy=0 next cycle. A restarted full run then produces the correct full sequence.
- Re-trigger and ignored start: pulse start during LOAD and EMIT → no effect. Start one cycle after done → a new LOAD is accepted with in_ready high on the following cycle.

Source files
------------

// File: rtl/pow2_decomp_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : pow2_decomp_stream_if
// Description : Stream bundle for pow2_decomp_stream. Carries the coefficient
//               load stream (in_data/in_valid/in_ready) and the expanded
//               output stream (out_data/out_pow/out_idx/out_last/out_valid/
//               out_ready).
//               slave  : the expander block
//               master : the surrounding logic (sampler / key assembler)
// Revision    : 1.0 - initial release
// ============================================================================
interface pow2_decomp_stream_if #(
    parameter int W = 10,
    parameter int N = 1024,
    parameter int K = 40
) ();
    localparam int c_idx_w = (N > 1) ? $clog2(N) : 1;
    localparam int c_pow_w = (K > 1) ? $clog2(K) : 1;

    logic [W-1:0]       in_data;
    logic               in_valid;
    logic               in_ready;

    logic [W-1:0]       out_data;
    logic [c_pow_w-1:0] out_pow;
    logic [c_idx_w-1:0] out_idx;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid,
        output in_ready,
        output out_data, out_pow, out_idx, out_last, out_valid,
        input  out_ready
    );

    modport master (
        output in_data, in_valid,
        input  in_ready,
        input  out_data, out_pow, out_idx, out_last, out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/pow2_decomp_stream.sv
`default_nettype none
// ============================================================================
// Module      : pow2_decomp_stream
// Description : Streaming powers-of-two expander. Loads an N-coefficient
//               polynomial s, then emits s*2^i (i = 0..K-1), power-major and
//               coefficient-minor. Each emitted coefficient is doubled and
//               written back in place, so the buffer always holds the next
//               power to be emitted.
//               Build option: POW2_MODRED_EN
//                 defined   - input reduced once against Q, doubling mod Q
//                 undefined - input stored as-is, doubling is a W-bit shift
// Ports       : clk, reset  - clock, synchronous active-high reset
//               start       - begin a run (sampled in IDLE only)
//               busy        - high whenever not IDLE
//               done        - one-cycle pulse after the final output beat
//               bus (slave) - load stream in, expanded stream out
// Revision    : 1.0 - initial release
// ============================================================================
module pow2_decomp_stream #(
    parameter int N = 1024,
    parameter int K = 40,
    parameter int W = 10,
    parameter int Q = 1009
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               start,
    output logic                    busy,
    output logic                    done,
    pow2_decomp_stream_if.slave     bus
);
    localparam int c_idx_w = (N > 1) ? $clog2(N) : 1;
    localparam int c_pow_w = (K > 1) ? $clog2(K) : 1;

    // Elaboration-time parameter sanity checks.
    if (N < 2) begin : g_bad_n
        $error("pow2_decomp_stream: N must be at least 2");
    end
    if (K < 1) begin : g_bad_k
        $error("pow2_decomp_stream: K must be at least 1");
    end
    if ((Q < 2) || (Q >= (1 << W))) begin : g_bad_q
        $error("pow2_decomp_stream: Q must satisfy 2 <= Q < 2^W");
    end

`ifdef POW2_MODRED_EN
    localparam logic [W-1:0] c_q     = Q[W-1:0];
    localparam logic [W:0]   c_q_ext = Q[W:0];
`endif

    // ------------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------------
    function automatic logic [W-1:0] f_reduce_in(input logic [W-1:0] x);
`ifdef POW2_MODRED_EN
        // A single subtract is enough: x < 2^W < 2Q is not guaranteed, but
        // only one conditional subtract is applied by design.
        return (x >= c_q) ? (x - c_q) : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [W-1:0] f_dbl(input logic [W-1:0] x);
`ifdef POW2_MODRED_EN
        logic [W:0] t;
        t = {x, 1'b0};
        if (t >= c_q_ext) begin
            t = t - c_q_ext;
        end
        return t[W-1:0];
`else
        return {x[W-2:0], 1'b0};
`endif
    endfunction

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [W-1:0]       r_buf [N];
    logic [c_idx_w-1:0] r_ld_idx;
    logic [c_idx_w-1:0] r_rd_idx;
    logic [c_pow_w-1:0] r_rd_pow;
    logic               r_prime;
    logic               r_rd_done;

    logic [W-1:0]       r_out_data;
    logic [c_pow_w-1:0] r_out_pow;
    logic [c_idx_w-1:0] r_out_idx;
    logic               r_out_last;
    logic               r_out_valid;

    logic               w_ld_fire;
    logic               w_ld_last;
    logic               w_out_fire;
    logic               w_fetch;
    logic               w_rd_last_idx;
    logic               w_rd_last;
    logic [W-1:0]       w_rd_data;

    assign w_ld_fire     = (r_state == S_LOAD) && bus.in_valid;
    assign w_ld_last     = w_ld_fire && (r_ld_idx == c_idx_w'(N - 1));
    assign w_out_fire    = r_out_valid && bus.out_ready;
    assign w_rd_last_idx = (r_rd_idx == c_idx_w'(N - 1));
    assign w_rd_last     = w_rd_last_idx && (r_rd_pow == c_pow_w'(K - 1));
    assign w_rd_data     = r_buf[r_rd_idx];

    // The output register refills whenever it is empty or being drained,
    // which gives one beat per cycle across pass boundaries. r_prime holds
    // off the very first fetch for one cycle after the last load beat.
    assign w_fetch = (r_state == S_EMIT) && !r_prime && !r_rd_done &&
                     (!r_out_valid || bus.out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start)                     w_state_next = S_LOAD;
            S_LOAD: if (w_ld_last)                 w_state_next = S_EMIT;
            S_EMIT: if (w_out_fire && r_out_last)  w_state_next = S_DONE;
            S_DONE:                                w_state_next = S_IDLE;
            default:                               w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ld_idx    <= '0;
            r_rd_idx    <= '0;
            r_rd_pow    <= '0;
            r_prime     <= 1'b0;
            r_rd_done   <= 1'b0;
            r_out_data  <= '0;
            r_out_pow   <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_ld_fire) begin
                r_ld_idx <= w_ld_last ? '0 : (r_ld_idx + 1'b1);
            end

            if (w_ld_last) begin
                r_prime   <= 1'b1;
                r_rd_idx  <= '0;
                r_rd_pow  <= '0;
                r_rd_done <= 1'b0;
            end else begin
                r_prime   <= 1'b0;
            end

            if (w_fetch) begin
                r_out_data  <= w_rd_data;
                r_out_pow   <= r_rd_pow;
                r_out_idx   <= r_rd_idx;
                r_out_last  <= w_rd_last;
                r_out_valid <= 1'b1;
                if (w_rd_last) begin
                    r_rd_done <= 1'b1;
                end else if (w_rd_last_idx) begin
                    r_rd_idx  <= '0;
                    r_rd_pow  <= r_rd_pow + 1'b1;
                end else begin
                    r_rd_idx  <= r_rd_idx + 1'b1;
                end
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Coefficient buffer. Load writes and emit write-backs never coincide
    // (different states). The write-back of beat j always lands at least one
    // cycle before coefficient j is fetched again in the next pass (N >= 2).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_ld_fire) begin
            r_buf[r_ld_idx] <= f_reduce_in(bus.in_data);
        end else if (w_out_fire) begin
            r_buf[r_out_idx] <= f_dbl(r_out_data);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.out_data  = r_out_data;
    assign bus.out_pow   = r_out_pow;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;
    assign bus.out_valid = r_out_valid;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_pow2_decomp_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_pow2_decomp_stream
// Description : Self-checking bench for pow2_decomp_stream (N=4, K=3, W=5,
//               Q=17). Table vectors with hand-computed expectations, hand
//               sequences for back-pressure / reset / re-trigger, and random
//               loads checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pow2_decomp_stream;
    localparam int N  = 4;
    localparam int K  = 3;
    localparam int W  = 5;
    localparam int Q  = 17;
    localparam int NB = N * K;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    pow2_decomp_stream_if #(.W(W), .N(N), .K(K)) bus ();

    pow2_decomp_stream #(.N(N), .K(K), .W(W), .Q(Q)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    typedef logic [0:N-1][W-1:0]  ld_t;
    typedef logic [0:NB-1][W-1:0] ex_t;
    typedef struct packed {
        ld_t ld;
        ex_t ex;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: beat b carries coefficient b%N raised to power b/N.
    function automatic ex_t model(input ld_t ld);
        ex_t m;
        for (int b = 0; b < NB; b++) begin
            int s;
            int v;
            s = int'(ld[b % N]);
`ifdef POW2_MODRED_EN
            if (s >= Q) s = s - Q;
            v = (s * (1 << (b / N))) % Q;
`else
            v = (s << (b / N)) % (1 << W);
`endif
            m[b] = W'(v);
        end
        return m;
    endfunction

    // One full run: start, load, emit. abort_at >= 0 asserts reset once that
    // many beats have been accepted.
    task automatic run(input ld_t ld, input ex_t ex, input int stall_pct,
                       input bit noisy_start, input int abort_at);
        int j;
        int b;
        int guard;
        bit stalled;
        logic [W-1:0] h_data;
        logic [31:0]  h_pow;
        logic [31:0]  h_idx;
        logic         h_last;

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_ready", bus.in_ready, 1);
        chk("start_busy", busy, 1);

        j = 0;
        guard = 0;
        while (j < N && guard < 1000) begin
            bus.in_valid = ($urandom_range(99) >= stall_pct);
            bus.in_data  = bus.in_valid ? ld[j] : W'($urandom);
            start        = noisy_start ? 1'($urandom) : 1'b0;
            if (bus.in_valid && bus.in_ready) j++;
            tick();
            guard++;
        end
        if (guard >= 1000) chk("load_timeout", guard, 0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        if (stall_pct == 0) begin
            chk("lat_e0_valid", bus.out_valid, 0);
            tick();
            chk("lat_e1_valid", bus.out_valid, 0);
            tick();
            chk("lat_e2_valid", bus.out_valid, 1);
        end

        b = 0;
        guard = 0;
        stalled = 1'b0;
        h_data = '0; h_pow = '0; h_idx = '0; h_last = 1'b0;
        while (b < NB && guard < 2000 && b != abort_at) begin
            start         = noisy_start ? 1'($urandom) : 1'b0;
            bus.out_ready = ($urandom_range(99) >= stall_pct);
            if (bus.out_valid) begin
                if (stalled) begin
                    chk("hold_data", bus.out_data, h_data);
                    chk("hold_pow",  bus.out_pow,  h_pow);
                    chk("hold_idx",  bus.out_idx,  h_idx);
                    chk("hold_last", bus.out_last, h_last);
                end
                if (bus.out_ready) begin
                    chk("out_data", bus.out_data, ex[b]);
                    chk("out_pow",  bus.out_pow,  b / N);
                    chk("out_idx",  bus.out_idx,  b % N);
                    chk("out_last", bus.out_last, (b == NB - 1) ? 1 : 0);
                    b++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    h_data = bus.out_data;
                    h_pow  = bus.out_pow;
                    h_idx  = bus.out_idx;
                    h_last = bus.out_last;
                end
            end
            tick();
            guard++;
        end
        start         = 1'b0;
        bus.out_ready = 1'b0;
        if (guard >= 2000) chk("emit_timeout", guard, 0);

        if (b == abort_at) begin
            reset = 1'b1;
            tick();
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data",  bus.out_data,  0);
            chk("rst_out_pow",   bus.out_pow,   0);
            chk("rst_out_idx",   bus.out_idx,   0);
            chk("rst_out_last",  bus.out_last,  0);
            chk("rst_in_ready",  bus.in_ready,  0);
            chk("rst_busy",      busy,          0);
            chk("rst_done",      done,          0);
            reset = 1'b0;
        end else begin
            if (stall_pct == 0) chk("emit_cycles", guard, NB);
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 1);
            chk("done_out_valid", bus.out_valid, 0);
            tick();
            chk("done_clear", done, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    vec_t vecs [3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ld_t rl;

`ifdef POW2_MODRED_EN
        vecs[0] = '{ld: {5'd1, 5'd5, 5'd16, 5'd9},
                    ex: {5'd1, 5'd5, 5'd16, 5'd9, 5'd2, 5'd10, 5'd15, 5'd1,
                         5'd4, 5'd3, 5'd13, 5'd2}};
        vecs[1] = '{ld: {5'd17, 5'd0, 5'd3, 5'd20},
                    ex: {5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd0, 5'd6, 5'd6,
                         5'd0, 5'd0, 5'd12, 5'd12}};
        vecs[2] = '{ld: {5'd31, 5'd31, 5'd31, 5'd31},
                    ex: {5'd14, 5'd14, 5'd14, 5'd14, 5'd11, 5'd11, 5'd11, 5'd11,
                         5'd5, 5'd5, 5'd5, 5'd5}};
`else
        vecs[0] = '{ld: {5'd1, 5'd5, 5'd16, 5'd9},
                    ex: {5'd1, 5'd5, 5'd16, 5'd9, 5'd2, 5'd10, 5'd0, 5'd18,
                         5'd4, 5'd20, 5'd0, 5'd4}};
        vecs[1] = '{ld: {5'd17, 5'd0, 5'd3, 5'd20},
                    ex: {5'd17, 5'd0, 5'd3, 5'd20, 5'd2, 5'd0, 5'd6, 5'd8,
                         5'd4, 5'd0, 5'd12, 5'd16}};
        vecs[2] = '{ld: {5'd31, 5'd31, 5'd31, 5'd31},
                    ex: {5'd31, 5'd31, 5'd31, 5'd31, 5'd30, 5'd30, 5'd30, 5'd30,
                         5'd28, 5'd28, 5'd28, 5'd28}};
`endif
        $display("[TB] config N=%0d K=%0d W=%0d Q=%0d", N, K, W, Q);

        reset         = 1'b1;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("reset_in_ready",  bus.in_ready,  0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_data",  bus.out_data,  0);
        chk("reset_out_pow",   bus.out_pow,   0);
        chk("reset_out_idx",   bus.out_idx,   0);
        chk("reset_out_last",  bus.out_last,  0);
        chk("reset_busy",      busy,          0);
        chk("reset_done",      done,          0);
        reset = 1'b0;
        tick();

        // Table vectors, stall-free; each run starts right after the previous
        // done cycle, so back-to-back restart is exercised as well.
        for (int v = 0; v < 3; v++) begin
            run(vecs[v].ld, vecs[v].ex, 0, 1'b0, -1);
        end

        // Back-pressure with start noise during LOAD and EMIT.
        run(vecs[0].ld, vecs[0].ex, 50, 1'b1, -1);

        // Reset at beat 6, then a clean full run.
        run(vecs[0].ld, vecs[0].ex, 0, 1'b0, 6);
        tick();
        run(vecs[0].ld, vecs[0].ex, 0, 1'b0, -1);

        // Random loads against the reference model.
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < N; j++) rl[j] = W'($urandom);
            run(rl, model(rl), 30, 1'b1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
